// File: rtl/iterative_math_unit.sv
// Iterative POWER / FACTORIAL / MULTIPLY unit built around one shared W x W multiplier.
// Optional build macro ITERATIVE_MATH_UNIT_SAT_EN: an overflowed result is reported as all ones.
module iterative_math_unit #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] operand_a,
    input  logic [W-1:0] operand_b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         ovf,
    output logic         err
);

`ifdef ITERATIVE_MATH_UNIT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam logic [1:0] OP_POWER = 2'b00;
    localparam logic [1:0] OP_FACT  = 2'b01;
    localparam logic [1:0] OP_MUL   = 2'b10;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state_reg;
    logic [1:0]   op_reg;
    logic [W-1:0] a_reg;
    logic [W-1:0] b_reg;
    logic [W-1:0] acc_reg;
    logic [W-1:0] cnt_reg;
    logic         ovf_run_reg;
    logic         busy_reg;
    logic         done_reg;
    logic [W-1:0] result_reg;
    logic         ovf_reg;
    logic         err_reg;

    logic [W-1:0]   mul_x;
    logic [W-1:0]   mul_y;
    logic [2*W-1:0] product;
    logic           prod_hi;
    logic           fin;
    logic [W-1:0]   fin_val;
    logic           fin_ovf;
    logic           fin_err;

    // Operand selection for the single multiplier, steered by the latched op.
    always_comb begin
        mul_x = acc_reg;
        mul_y = a_reg;
        case (op_reg)
            OP_FACT: mul_y = cnt_reg;
            OP_MUL: begin
                mul_x = a_reg;
                mul_y = b_reg;
            end
            default: mul_y = a_reg;
        endcase
        product = {{W{1'b0}}, mul_x} * {{W{1'b0}}, mul_y};
        prod_hi = |product[2*W-1:W];
    end

    // Decide whether this RUN cycle finishes and what value/flags it finishes with.
    always_comb begin
        fin     = 1'b0;
        fin_val = acc_reg;
        fin_ovf = ovf_run_reg;
        fin_err = 1'b0;
        case (op_reg)
            OP_POWER: fin = (cnt_reg == '0);
            OP_FACT:  fin = (cnt_reg <= W'(1));
            OP_MUL: begin
                fin     = 1'b1;
                fin_val = product[W-1:0];
                fin_ovf = prod_hi;
            end
            default: begin
                fin     = 1'b1;
                fin_val = '0;
                fin_ovf = 1'b0;
                fin_err = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            op_reg      <= 2'b00;
            a_reg       <= '0;
            b_reg       <= '0;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            ovf_run_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            result_reg  <= '0;
            ovf_reg     <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        op_reg      <= op;
                        a_reg       <= operand_a;
                        b_reg       <= operand_b;
                        acc_reg     <= W'(1);
                        cnt_reg     <= (op == OP_POWER) ? operand_b : operand_a;
                        ovf_run_reg <= 1'b0;
                        ovf_reg     <= 1'b0;
                        err_reg     <= 1'b0;
                        busy_reg    <= 1'b1;
                        state_reg   <= RUN;
                    end
                end
                RUN: begin
                    if (fin) begin
                        acc_reg    <= fin_val;
                        result_reg <= (SAT && fin_ovf) ? {W{1'b1}} : fin_val;
                        ovf_reg    <= fin_ovf;
                        err_reg    <= fin_err;
                        busy_reg   <= 1'b0;
                        done_reg   <= 1'b1;
                        state_reg  <= DONE;
                    end else begin
                        // Keep the wrapped low half; any high bit makes overflow sticky.
                        acc_reg     <= product[W-1:0];
                        cnt_reg     <= cnt_reg - W'(1);
                        ovf_run_reg <= ovf_run_reg | prod_hi;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = result_reg;
    assign ovf    = ovf_reg;
    assign err    = err_reg;

endmodule
